// File: rtl/counter_arbiter_if.sv
// Request/grant bundle between the requesters, the arbiter and the shared binary_counter.
// The slave side is the arbiter; the master side is whoever drives the requests and owns the counter.
interface counter_arbiter_if #(
    parameter int WIDTH = 4,
    parameter int N_REQ = 2
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] length;
    logic [N_REQ-1:0]       grant;
    logic [N_REQ-1:0]       done;
    logic                   busy;
    logic                   counter_clear;
    logic                   counter_count;
    logic [WIDTH-1:0]       counter_q;

    modport master (
        output req, length, counter_q,
        input  grant, done, busy, counter_clear, counter_count
    );

    modport slave (
        input  req, length, counter_q,
        output grant, done, busy, counter_clear, counter_count
    );
endinterface

// File: rtl/counter_arbiter.sv
// Round-robin arbiter that lends one binary_counter to N_REQ requesters in turn:
// clear it, count up to the winner's latched length, then pulse done.
module counter_arbiter #(
    parameter int WIDTH = 4,
    parameter int N_REQ = 2
) (
    input  logic clock,
    input  logic reset,
    counter_arbiter_if.slave bus
);
    localparam int IDXW = $clog2(N_REQ);
    localparam logic [IDXW:0]   NREQ_W   = (IDXW+1)'(N_REQ);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N_REQ - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_COUNT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       r_state;
    logic [N_REQ-1:0] r_grant;
    logic [N_REQ-1:0] r_done;
    logic [IDXW-1:0]  r_ptr;
    logic [IDXW-1:0]  r_idx;
    logic [WIDTH-1:0] r_len;

    logic             w_found;
    logic [IDXW-1:0]  w_sel;
    logic [IDXW:0]    w_cand;
    logic [WIDTH-1:0] w_selLen;
    logic [IDXW-1:0]  w_nextPtr;
    logic             w_live;
    logic             w_atLen;

    // First requester at or after the pointer, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_cand = {1'b0, r_ptr} + (IDXW+1)'(k);
            if (w_cand >= NREQ_W) begin
                w_cand = w_cand - NREQ_W;
            end
            if (!w_found && bus.req[w_cand[IDXW-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_cand[IDXW-1:0];
            end
        end
    end

    assign w_selLen  = bus.length[w_sel*WIDTH +: WIDTH];
    assign w_nextPtr = (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
    assign w_live    = bus.req[r_idx];
    assign w_atLen   = (bus.counter_q == r_len);

    // Gating with w_live freezes the counter in the same cycle a requester withdraws.
    assign bus.busy          = (r_state != S_IDLE);
    assign bus.counter_clear = (r_state == S_CLEAR) && w_live;
    assign bus.counter_count = (r_state == S_COUNT) && w_live && !w_atLen;
    assign bus.grant         = r_grant;
    assign bus.done          = r_done;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_done  <= '0;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_len   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant <= {{(N_REQ-1){1'b0}}, 1'b1} << w_sel;
                        r_idx   <= w_sel;
                        r_len   <= w_selLen;
                        r_state <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (!w_live) begin
                        r_grant <= '0;
                        r_ptr   <= w_nextPtr;
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_COUNT;
                    end
                end
                S_COUNT: begin
                    if (!w_live) begin
                        r_grant <= '0;
                        r_ptr   <= w_nextPtr;
                        r_state <= S_IDLE;
                    end else if (w_atLen) begin
                        r_done  <= r_grant;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_grant <= '0;
                    r_done  <= '0;
                    r_ptr   <= w_nextPtr;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_counter_arbiter.sv
// Bench for counter_arbiter: a stand-in binary counter, directed corner cases and random
// request rounds, with expected grants queued by a round-robin model and checked by a monitor.
module tb_counter_arbiter;
    localparam int W = 4;
    localparam int N = 2;

    typedef struct {
        int idx;
        int len;
        int abortAt;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    logic cntReset;
    int   errors = 0;
    int   checks = 0;
    int   modelPtr = 0;
    int   strayDone = 0;
    exp_t expQ[$];

    always #5 clock = ~clock;

    counter_arbiter_if #(.WIDTH(W), .N_REQ(N)) bus();

    counter_arbiter #(.WIDTH(W), .N_REQ(N)) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    // Behavioural binary_counter with an active-high reset, as the arbiter expects to drive.
    assign cntReset = ~reset;
    always_ff @(posedge clock or posedge cntReset) begin
        if (cntReset) begin
            bus.counter_q <= '0;
        end else if (bus.counter_clear) begin
            bus.counter_q <= '0;
        end else if (bus.counter_count) begin
            bus.counter_q <= bus.counter_q + 1'b1;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int firstSetFrom(input logic [N-1:0] v, input int start);
        for (int k = 0; k < N; k++) begin
            if (v[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    // Each requester in turn, starting from the pointer; held vectors keep everyone eligible.
    task automatic predict(input logic [N-1:0] reqv, input logic [N*W-1:0] lens,
                           input int nGrants, input bit holdAll);
        logic [N-1:0] pending;
        int sel;
        exp_t e;
        pending = reqv;
        for (int g = 0; g < nGrants; g++) begin
            sel = firstSetFrom(pending, modelPtr);
            e.idx = sel;
            e.len = int'(lens[sel*W +: W]);
            e.abortAt = -1;
            expQ.push_back(e);
            modelPtr = (sel + 1) % N;
            if (!holdAll) pending[sel] = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] reqv, input logic [N*W-1:0] lens,
                                 input int nGrants, input bit holdAll);
        predict(reqv, lens, nGrants, holdAll);
        bus.length = lens;
        bus.req    = reqv;
    endtask

    task automatic waitDones(input int nDones, input bit holdAll, input bit scramble);
        bit found;
        int waited;
        for (int d = 0; d < nDones; d++) begin
            found  = 1'b0;
            waited = 0;
            while (!found && waited < 60) begin
                @(posedge clock);
                #1;
                waited++;
                if (bus.done != '0) begin
                    found = 1'b1;
                    if (!holdAll) bus.req = bus.req & ~bus.done;
                end else if (scramble && bus.grant != '0 && $urandom_range(0, 1) == 0) begin
                    for (int i = 0; i < N; i++) begin
                        if (bus.grant[i]) bus.length[i*W +: W] = W'($urandom);
                    end
                end
            end
            if (!found) begin
                checkOutput("done timeout", 0, 1);
                d = nDones;
            end
        end
        bus.req = '0;
        repeat (2) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic waitForQ(input int target);
        int waited;
        waited = 0;
        while (!(bus.counter_q == W'(target) && bus.grant[0] && !bus.counter_clear) && waited < 60) begin
            @(posedge clock);
            #1;
            waited++;
        end
        checkOutput("reached q target", waited < 60 ? 1 : 0, 1);
    endtask

    function automatic int onehotIdx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Monitor state for the grant currently being observed.
    bit           active = 1'b0;
    logic [N-1:0] curGrant;
    int gIdx, cycles, clears, pulses, doneCnt, doneAt, doneIdx, qAtDone, badInv;
    int zeroRun = 1;

    task automatic finalizeTxn(input int qNow);
        exp_t e;
        if (expQ.size() == 0) begin
            checkOutput("unexpected grant", gIdx, -1);
        end else begin
            e = expQ.pop_front();
            checkOutput("granted requester", gIdx, e.idx);
            checkOutput("clear pulses", clears, 1);
            checkOutput("handshake invariants", badInv, 0);
            if (e.abortAt < 0) begin
                checkOutput("done pulses", doneCnt, 1);
                checkOutput("done requester", doneIdx, e.idx);
                checkOutput("done cycle", doneAt, e.len + 3);
                checkOutput("count pulses", pulses, e.len);
                checkOutput("q at done", qAtDone, e.len);
                checkOutput("grant cycles", cycles, e.len + 3);
            end else begin
                checkOutput("abort done pulses", doneCnt, 0);
                checkOutput("abort count pulses", pulses, e.abortAt);
                checkOutput("abort q", qNow, e.abortAt);
                checkOutput("abort grant cycles", cycles, e.abortAt + 2);
            end
        end
    endtask

    // Scoreboard side: watches grants on falling edges and retires one expectation per release.
    always @(negedge clock) begin
        if (!reset) begin
            active  = 1'b0;
            zeroRun = 1;
        end else begin
            if (active && bus.grant != curGrant) begin
                finalizeTxn(int'(bus.counter_q));
                active = 1'b0;
            end
            if (!active && bus.grant != '0) begin
                checkOutput("idle gap before grant", zeroRun >= 1 ? 1 : 0, 1);
                active   = 1'b1;
                curGrant = bus.grant;
                gIdx     = onehotIdx(bus.grant);
                cycles = 0; clears = 0; pulses = 0; doneCnt = 0;
                doneAt = -1; doneIdx = -1; qAtDone = -1; badInv = 0;
            end
            if (active) begin
                cycles++;
                clears += int'(bus.counter_clear);
                pulses += int'(bus.counter_count);
                if ($countones(bus.grant) != 1 || !bus.busy) badInv++;
                if (bus.done != '0) begin
                    doneCnt++;
                    doneAt  = cycles;
                    doneIdx = onehotIdx(bus.done);
                    qAtDone = int'(bus.counter_q);
                    if (bus.done != bus.grant) badInv++;
                end
            end else if (bus.done != '0) begin
                strayDone++;
            end
            zeroRun = (bus.grant == '0) ? zeroRun + 1 : 0;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [N*W-1:0] lens;
        logic [N-1:0]   reqv;
        reset      = 1'b0;
        bus.req    = '0;
        bus.length = '0;
        #12;
        checkOutput("reset grant", int'(bus.grant), 0);
        checkOutput("reset done", int'(bus.done), 0);
        checkOutput("reset busy", int'(bus.busy), 0);
        checkOutput("reset clear", int'(bus.counter_clear), 0);
        checkOutput("reset count", int'(bus.counter_count), 0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;

        $display("[TB] contention: both requesters held, lengths 2 and 1");
        applyStimulus(2'b11, {4'd1, 4'd2}, 3, 1'b1);
        waitDones(3, 1'b1, 1'b0);

        $display("[TB] single request with length changed after grant");
        applyStimulus(2'b01, {4'd0, 4'd3}, 1, 1'b0);
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        bus.length[3:0] = 4'd9;
        waitDones(1, 1'b0, 1'b0);

        $display("[TB] zero length on requester 1");
        applyStimulus(2'b10, {4'd0, 4'd5}, 1, 1'b0);
        waitDones(1, 1'b0, 1'b0);

        $display("[TB] maximum length on requester 0");
        applyStimulus(2'b01, {4'd3, 4'd15}, 1, 1'b0);
        waitDones(1, 1'b0, 1'b0);

        $display("[TB] abort at q=4");
        expQ.push_back('{idx: 0, len: 8, abortAt: 4});
        modelPtr     = 1;
        bus.length   = {4'd2, 4'd8};
        bus.req      = 2'b01;
        waitForQ(4);
        bus.req = '0;
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        checkOutput("q held after abort", int'(bus.counter_q), 4);
        applyStimulus(2'b11, {4'd1, 4'd2}, 2, 1'b0);
        waitDones(2, 1'b0, 1'b0);

        $display("[TB] asynchronous reset during count");
        bus.length = {4'd1, 4'd10};
        bus.req    = 2'b01;
        waitForQ(3);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("mid reset grant", int'(bus.grant), 0);
        checkOutput("mid reset done", int'(bus.done), 0);
        checkOutput("mid reset busy", int'(bus.busy), 0);
        checkOutput("mid reset clear", int'(bus.counter_clear), 0);
        checkOutput("mid reset count", int'(bus.counter_count), 0);
        bus.req  = '0;
        modelPtr = 0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        applyStimulus(2'b11, {4'd2, 4'd1}, 2, 1'b0);
        waitDones(2, 1'b0, 1'b0);

        $display("[TB] random rounds");
        for (int r = 0; r < 40; r++) begin
            reqv = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 5))
                    0:       lens[i*W +: W] = '0;
                    1:       lens[i*W +: W] = '1;
                    default: lens[i*W +: W] = W'($urandom);
                endcase
            end
            applyStimulus(reqv, lens, $countones(reqv), 1'b0);
            waitDones($countones(reqv), 1'b0, 1'b1);
        end

        repeat (4) begin
            @(posedge clock);
            #1;
        end
        checkOutput("scoreboard drained", expQ.size(), 0);
        checkOutput("stray done pulses", strayDone, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
